// File: rtl/dma_chan_reg_loader.sv
`default_nettype none
// ============================================================================
// Module   : dma_chan_reg_loader
// Purpose  : Builds per-channel DMA address/word-count registers from a narrow
//            CPU bus, steps them on transfer pulses and flags terminal count.
// Revision : 1.0 - initial release
// ============================================================================
module dma_chan_reg_loader #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 8,
    parameter int REG_W     = 16,
    parameter int MSB_FIRST = 1
) (
    input  logic                                                    clk,
    input  logic                                                    RESET,
    input  logic                                                    wr_en,
    input  logic                                                    reg_sel,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]          ch_sel,
    input  logic [DATA_W-1:0]                                       data_bus,
    input  logic                                                    clr_ptr,
    input  logic [NUM_CH-1:0]                                       xfer,
    output logic [NUM_CH*REG_W-1:0]                                 address,
    output logic [NUM_CH*REG_W-1:0]                                 word_count,
    output logic [NUM_CH-1:0]                                       armed,
    output logic [NUM_CH-1:0]                                       tc,
    output logic                                                    load_done,
    output logic [((REG_W/DATA_W > 1) ? $clog2(REG_W/DATA_W) : 1)-1:0] ptr
);

    localparam int BYTES = REG_W / DATA_W;
    localparam int PTR_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BYTES - 1);

    logic [PTR_W-1:0]              ptr_q, ptr_d;
    logic [REG_W-1:0]              staging_q, staging_d;
    logic [NUM_CH-1:0][REG_W-1:0]  addr_q, addr_d;
    logic [NUM_CH-1:0][REG_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0]             addr_loaded_q, addr_loaded_d;
    logic [NUM_CH-1:0]             cnt_loaded_q, cnt_loaded_d;
    logic [NUM_CH-1:0]             armed_q, armed_d;
    logic [NUM_CH-1:0]             tc_q, tc_d;
    logic                          load_done_q, load_done_d;

    logic                          commit;
    logic [REG_W-1:0]              chunk_ext;
    logic [REG_W-1:0]              merged;

    always_comb begin
        ptr_d         = ptr_q;
        staging_d     = staging_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        addr_loaded_d = addr_loaded_q;
        cnt_loaded_d  = cnt_loaded_q;
        tc_d          = '0;
        load_done_d   = 1'b0;
        commit        = 1'b0;
        chunk_ext     = REG_W'(data_bus);

        // Staging is zero after every commit/clear, so unwritten bits stay zero.
        if (MSB_FIRST != 0) begin
            merged = (staging_q << DATA_W) | chunk_ext;
        end else begin
            merged = staging_q | (chunk_ext << (int'(ptr_q) * DATA_W));
        end

        if (clr_ptr) begin
            ptr_d     = '0;
            staging_d = '0;
        end else if (wr_en) begin
            if (ptr_q == LAST_PTR) begin
                commit      = 1'b1;
                load_done_d = 1'b1;
                ptr_d       = '0;
                staging_d   = '0;
            end else begin
                ptr_d     = ptr_q + PTR_W'(1);
                staging_d = merged;
            end
        end

        for (int c = 0; c < NUM_CH; c++) begin
            // A commit to this channel swallows any same-cycle transfer.
            if (commit && (ch_sel == CH_W'(c))) begin
                if (!reg_sel) begin
                    addr_d[c]        = merged;
                    addr_loaded_d[c] = 1'b1;
                end else begin
                    cnt_d[c]         = merged;
                    cnt_loaded_d[c]  = |merged;
                end
            end else if (xfer[c] && armed_q[c]) begin
                addr_d[c] = addr_q[c] + REG_W'(1);
                cnt_d[c]  = cnt_q[c] - REG_W'(1);
                if (cnt_q[c] == REG_W'(1)) begin
                    tc_d[c]         = 1'b1;
                    cnt_loaded_d[c] = 1'b0;
                end
            end
        end

        armed_d = addr_loaded_d & cnt_loaded_d;
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            ptr_q         <= '0;
            staging_q     <= '0;
            addr_q        <= '0;
            cnt_q         <= '0;
            addr_loaded_q <= '0;
            cnt_loaded_q  <= '0;
            armed_q       <= '0;
            tc_q          <= '0;
            load_done_q   <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            staging_q     <= staging_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            addr_loaded_q <= addr_loaded_d;
            cnt_loaded_q  <= cnt_loaded_d;
            armed_q       <= armed_d;
            tc_q          <= tc_d;
            load_done_q   <= load_done_d;
        end
    end

    assign address    = addr_q;
    assign word_count = cnt_q;
    assign armed      = armed_q;
    assign tc         = tc_q;
    assign load_done  = load_done_q;
    assign ptr        = ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_chan_reg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_chan_reg_loader
// Purpose  : Self-checking bench: vector table, corner sequences, random run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_chan_reg_loader;

    localparam int BYTES = 2;

    logic        clk = 1'b0;
    logic        RESET;
    logic        wr_en, reg_sel, clr_ptr;
    logic [1:0]  ch_sel;
    logic [7:0]  data_bus;
    logic [3:0]  xfer;
    logic [63:0] address, word_count;
    logic [3:0]  armed, tc;
    logic        load_done;
    logic [0:0]  ptr;

    logic        v_wr, v_rs, v_clr;
    logic [0:0]  v_ch;
    logic [7:0]  v_d;
    logic [1:0]  v_xf;
    logic [63:0] v_addr, v_cnt;
    logic [1:0]  v_armed, v_tc;
    logic        v_ld;
    logic [1:0]  v_ptr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dma_chan_reg_loader dut (
        .clk(clk), .RESET(RESET), .wr_en(wr_en), .reg_sel(reg_sel), .ch_sel(ch_sel),
        .data_bus(data_bus), .clr_ptr(clr_ptr), .xfer(xfer), .address(address),
        .word_count(word_count), .armed(armed), .tc(tc), .load_done(load_done), .ptr(ptr)
    );

    dma_chan_reg_loader #(.NUM_CH(2), .DATA_W(8), .REG_W(32), .MSB_FIRST(0)) dut_v (
        .clk(clk), .RESET(RESET), .wr_en(v_wr), .reg_sel(v_rs), .ch_sel(v_ch),
        .data_bus(v_d), .clr_ptr(v_clr), .xfer(v_xf), .address(v_addr),
        .word_count(v_cnt), .armed(v_armed), .tc(v_tc), .load_done(v_ld), .ptr(v_ptr)
    );

    typedef struct packed {
        logic        wr;
        logic        rs;
        logic [1:0]  ch;
        logic [7:0]  d;
        logic [3:0]  xf;
        logic        e_ptr;
        logic        e_ld;
        logic [3:0]  e_armed;
        logic [3:0]  e_tc;
        logic [15:0] e_addr;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [10];

    // Reference model state
    int unsigned m_addr [4];
    int unsigned m_cnt  [4];
    bit          m_al   [4];
    bit          m_cl   [4];
    bit   [3:0]  m_tc;
    bit          m_ld;
    logic [7:0]  m_chunks [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic w, input logic rs, input logic [1:0] ch,
                       input logic [7:0] d, input logic clr, input logic [3:0] xf);
        wr_en = w; reg_sel = rs; ch_sel = ch; data_bus = d; clr_ptr = clr; xfer = xf;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 4'h0);
    endtask

    task automatic wr16(input logic [1:0] ch, input logic rs, input logic [15:0] val);
        drv(1'b1, rs, ch, val[15:8], 1'b0, 4'h0);
        tick();
        drv(1'b1, rs, ch, val[7:0], 1'b0, 4'h0);
        tick();
        idle();
    endtask

    function automatic logic [15:0] addr_of(input int c);
        return address[c*16 +: 16];
    endfunction

    function automatic logic [15:0] cnt_of(input int c);
        return word_count[c*16 +: 16];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_addr[c] = 0; m_cnt[c] = 0; m_al[c] = 0; m_cl[c] = 0;
        end
        m_tc = '0; m_ld = 0;
        m_chunks.delete();
    endtask

    task automatic model_step(input bit w, input bit rs, input int ch, input logic [7:0] d,
                              input bit clr, input logic [3:0] xf);
        bit [3:0]    armed_prev;
        int          cc;
        int unsigned val;
        cc = -1;
        for (int c = 0; c < 4; c++) armed_prev[c] = m_al[c] && m_cl[c];
        m_tc = '0;
        m_ld = 0;
        if (clr) begin
            m_chunks.delete();
        end else if (w) begin
            m_chunks.push_back(d);
            if (m_chunks.size() == BYTES) begin
                val = 0;
                for (int k = 0; k < BYTES; k++) val = val * 256 + m_chunks[k];
                m_chunks.delete();
                m_ld = 1;
                cc   = ch;
                if (rs) begin
                    m_cnt[ch] = val; m_cl[ch] = (val != 0);
                end else begin
                    m_addr[ch] = val; m_al[ch] = 1;
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (c != cc && xf[c] && armed_prev[c]) begin
                m_addr[c] = (m_addr[c] + 1) % 65536;
                m_cnt[c]  = m_cnt[c] - 1;
                if (m_cnt[c] == 0) begin
                    m_tc[c] = 1; m_cl[c] = 0;
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic [3:0] exp_armed;

        RESET = 1'b1;
        idle();
        v_wr = 0; v_rs = 0; v_ch = 0; v_d = 0; v_clr = 0; v_xf = 0;
        tick(); tick();
        RESET = 1'b0;
        tick();

        chk("rst ptr", 64'(ptr), 64'd0);
        chk("rst load_done", 64'(load_done), 64'd0);
        chk("rst armed", 64'(armed), 64'd0);
        chk("rst tc", 64'(tc), 64'd0);
        chk("rst address", address, 64'd0);
        chk("rst word_count", word_count, 64'd0);

        // wr rs ch d xf | ptr ld armed tc addr2 cnt2
        tbl[0] = '{1'b1, 1'b0, 2'd2, 8'h12, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 16'h0000, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 2'd2, 8'h34, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 16'h1234, 16'h0000};
        tbl[2] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 16'h1234, 16'h0000};
        tbl[3] = '{1'b1, 1'b0, 2'd1, 8'h00, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 16'h1234, 16'h0000};
        tbl[4] = '{1'b1, 1'b1, 2'd2, 8'h03, 4'h0, 1'b0, 1'b1, 4'h4, 4'h0, 16'h1234, 16'h0003};
        tbl[5] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'h4, 1'b0, 1'b0, 4'h4, 4'h0, 16'h1235, 16'h0002};
        tbl[6] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'h4, 1'b0, 1'b0, 4'h4, 4'h0, 16'h1236, 16'h0001};
        tbl[7] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'h4, 1'b0, 1'b0, 4'h0, 4'h4, 16'h1237, 16'h0000};
        tbl[8] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'h4, 1'b0, 1'b0, 4'h0, 4'h0, 16'h1237, 16'h0000};
        tbl[9] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 16'h1237, 16'h0000};

        for (int i = 0; i < 10; i++) begin
            drv(tbl[i].wr, tbl[i].rs, tbl[i].ch, tbl[i].d, 1'b0, tbl[i].xf);
            tick();
            chk($sformatf("vec%0d ptr", i), 64'(ptr), 64'(tbl[i].e_ptr));
            chk($sformatf("vec%0d load_done", i), 64'(load_done), 64'(tbl[i].e_ld));
            chk($sformatf("vec%0d armed", i), 64'(armed), 64'(tbl[i].e_armed));
            chk($sformatf("vec%0d tc", i), 64'(tc), 64'(tbl[i].e_tc));
            chk($sformatf("vec%0d addr2", i), 64'(addr_of(2)), 64'(tbl[i].e_addr));
            chk($sformatf("vec%0d cnt2", i), 64'(cnt_of(2)), 64'(tbl[i].e_cnt));
        end

        // Pointer clear drops the pending and the same-cycle chunk
        drv(1'b1, 1'b0, 2'd0, 8'hAA, 1'b0, 4'h0); tick();
        chk("clr ptr after AA", 64'(ptr), 64'd1);
        drv(1'b1, 1'b0, 2'd0, 8'hBB, 1'b1, 4'h0); tick();
        chk("clr ptr after clr", 64'(ptr), 64'd0);
        chk("clr no load_done", 64'(load_done), 64'd0);
        drv(1'b1, 1'b0, 2'd0, 8'h56, 1'b0, 4'h0); tick();
        chk("clr ptr after 56", 64'(ptr), 64'd1);
        drv(1'b1, 1'b0, 2'd0, 8'h78, 1'b0, 4'h0); tick();
        idle();
        chk("clr load_done", 64'(load_done), 64'd1);
        chk("clr addr0", 64'(addr_of(0)), 64'h5678);

        // Address wrap and terminal count on channel 1
        wr16(2'd1, 1'b0, 16'hFFFF);
        wr16(2'd1, 1'b1, 16'h0002);
        chk("wrap armed1", 64'(armed[1]), 64'd1);
        drv(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 4'b0010); tick();
        chk("wrap addr1 a", 64'(addr_of(1)), 64'h0000);
        chk("wrap cnt1 a", 64'(cnt_of(1)), 64'h0001);
        chk("wrap tc a", 64'(tc), 64'h0);
        tick();
        idle();
        chk("wrap addr1 b", 64'(addr_of(1)), 64'h0001);
        chk("wrap cnt1 b", 64'(cnt_of(1)), 64'h0000);
        chk("wrap tc b", 64'(tc), 64'b0010);
        chk("wrap armed1 b", 64'(armed[1]), 64'd0);
        tick();
        chk("wrap tc clears", 64'(tc), 64'h0);

        // Commit colliding with a transfer on channel 3
        wr16(2'd3, 1'b0, 16'h0040);
        wr16(2'd3, 1'b1, 16'h0005);
        chk("coll armed3", 64'(armed[3]), 64'd1);
        drv(1'b1, 1'b1, 2'd3, 8'h00, 1'b0, 4'h0); tick();
        drv(1'b1, 1'b1, 2'd3, 8'h10, 1'b0, 4'b1000); tick();
        idle();
        chk("coll cnt3", 64'(cnt_of(3)), 64'h0010);
        chk("coll addr3", 64'(addr_of(3)), 64'h0040);
        chk("coll tc", 64'(tc), 64'h0);
        chk("coll armed3 kept", 64'(armed[3]), 64'd1);
        wr16(2'd3, 1'b1, 16'h0000);
        chk("zero cnt armed3", 64'(armed[3]), 64'd0);
        chk("zero cnt3", 64'(cnt_of(3)), 64'h0000);

        // Asynchronous reset mid-sequence
        drv(1'b1, 1'b0, 2'd0, 8'h12, 1'b0, 4'h0); tick();
        idle();
        chk("mid ptr", 64'(ptr), 64'd1);
        #2 RESET = 1'b1;
        #1;
        chk("async rst ptr", 64'(ptr), 64'd0);
        chk("async rst address", address, 64'd0);
        chk("async rst count", word_count, 64'd0);
        chk("async rst armed", 64'(armed), 64'd0);
        tick();
        RESET = 1'b0;
        drv(1'b1, 1'b0, 2'd0, 8'h9A, 1'b0, 4'h0); tick();
        chk("restart ptr", 64'(ptr), 64'd1);
        drv(1'b1, 1'b0, 2'd0, 8'hBC, 1'b0, 4'h0); tick();
        idle();
        chk("restart addr0", 64'(addr_of(0)), 64'h9ABC);

        // LSB-first 32-bit variant
        for (int k = 0; k < 4; k++) begin
            v_wr = 1'b1;
            v_d  = 8'((k + 1) * 17);
            tick();
            chk($sformatf("var ptr%0d", k), 64'(v_ptr), 64'((k + 1) % 4));
        end
        v_wr = 1'b0;
        chk("var load_done", 64'(v_ld), 64'd1);
        chk("var addr0", 64'(v_addr[31:0]), 64'h44332211);

        // Randomized run against the reference model
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        model_reset();
        for (int n = 0; n < 2000; n++) begin
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom) :
                (($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 3)));
            drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                d, ($urandom_range(0, 19) == 0), 4'($urandom));
            model_step(wr_en, reg_sel, int'(ch_sel), data_bus, clr_ptr, xfer);
            tick();
            for (int c = 0; c < 4; c++) begin
                exp_armed[c] = m_al[c] && m_cl[c];
                chk($sformatf("rnd%0d addr%0d", n, c), 64'(addr_of(c)), 64'(m_addr[c]));
                chk($sformatf("rnd%0d cnt%0d", n, c), 64'(cnt_of(c)), 64'(m_cnt[c]));
            end
            chk($sformatf("rnd%0d ptr", n), 64'(ptr), 64'(m_chunks.size()));
            chk($sformatf("rnd%0d load_done", n), 64'(load_done), 64'(m_ld));
            chk($sformatf("rnd%0d armed", n), 64'(armed), 64'(exp_armed));
            chk($sformatf("rnd%0d tc", n), 64'(tc), 64'(m_tc));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
